// File: rtl/load_store_unit.sv
// load_store_unit: computes the effective address, checks alignment, runs one
// enable/ready handshake on the memory controller and returns extended load data.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base,
  input  logic [31:0]       offset,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              mem_enable,
  output logic [1:0]        mem_mode,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_op_r
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [WdogW-1:0]  wdog_q, wdog_d, wdog_inc;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, en_q, en_d;
  logic [31:0]       load_data_q, load_data_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_mode_q, mem_mode_d, mode_req;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] ea;
  logic              req_bad, timeout_hit;

  // Only the forwarded address bits matter; mod 2^32 wrap leaves them unchanged.
  assign ea          = ADDR_W'(base + offset);
  assign wdog_inc    = wdog_q + WdogW'(1);
  assign timeout_hit = (wdog_inc == WdogW'(TIMEOUT));

  // Request legality: unknown width codes, unsigned stores and misalignment.
  always_comb begin
    req_bad = 1'b0;
    case (funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = ea[0];
      3'b010:  req_bad = (ea[1:0] != 2'b00);
      3'b100:  req_bad = is_store;
      3'b101:  req_bad = is_store | ea[0];
      default: req_bad = 1'b1;
    endcase
  end

  // Controller mode encoding from the width code.
  always_comb begin
    case (funct3[1:0])
      2'b00:   mode_req = 2'b01;
      2'b01:   mode_req = 2'b10;
      default: mode_req = 2'b00;
    endcase
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] rd);
    case (f3)
      3'b000:  extend = {{24{rd[7]}}, rd[7:0]};
      3'b001:  extend = {{16{rd[15]}}, rd[15:0]};
      3'b100:  extend = {24'b0, rd[7:0]};
      3'b101:  extend = {16'b0, rd[15:0]};
      default: extend = rd;
    endcase
  endfunction

  // State and watchdog register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state logic; a ready strobe beats the watchdog on the same cycle.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = req_bad ? StDone : StIssue;
      end
      StIssue: begin
        state_d = StWait;
        wdog_d  = '0;
      end
      StWait: begin
        if (mem_op_r) begin
          state_d = StDone;
        end else begin
          wdog_d = wdog_inc;
          if (timeout_hit) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // Output and datapath next values, registered so every output comes from a flop.
  always_comb begin
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    en_d        = (state_d == StIssue);
    err_d       = 1'b0;
    load_data_d = load_data_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    funct3_d    = funct3_q;
    if (state_q == StIdle && start) begin
      err_d       = req_bad;
      mem_addr_d  = ea;
      mem_we_d    = is_store;
      mem_wdata_d = store_data;
      mem_mode_d  = mode_req;
      funct3_d    = funct3;
    end
    if (state_q == StWait) begin
      if (mem_op_r) begin
        if (!mem_we_q) load_data_d = extend(funct3_q, mem_rdata);
      end else begin
        err_d = timeout_hit;
      end
    end
  end

  // Output and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      load_data_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_mode_q  <= '0;
      funct3_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      en_q        <= en_d;
      load_data_q <= load_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      funct3_q    <= funct3_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_enable = en_q;
  assign load_data  = load_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mode   = mem_mode_q;

endmodule
